// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-number judge stage.
package guess_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_ENTRY,
        ST_CHECK,
        ST_SCORE,
        ST_WON,
        ST_LOST
    } state_t;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_ENT = 4'hB;

    localparam int DEF_DIGITS    = 4;
    localparam int DEF_MAX_TRIES = 10;

endpackage

// File: rtl/guess_digit_check.sv
// Combinational well-formed check on a BCD word: every nibble 0..9 and all nibbles distinct.
module guess_digit_check
    import guess_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    output logic                o_valid
);

    logic [DIGITS-1:0]        w_in_range;
    logic [DIGITS*DIGITS-1:0] w_dup;

    genvar gi, gj;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign w_in_range[gi] = (i_bcd[4*gi +: 4] <= 4'd9);
            // Only the upper triangle holds real pair comparisons.
            for (gj = 0; gj < DIGITS; gj++) begin : g_pair
                if (gj > gi) begin : g_cmp
                    assign w_dup[gi*DIGITS + gj] = (i_bcd[4*gi +: 4] == i_bcd[4*gj +: 4]);
                end else begin : g_none
                    assign w_dup[gi*DIGITS + gj] = 1'b0;
                end
            end
        end
    endgenerate

    assign o_valid = (&w_in_range) && !(|w_dup);

endmodule

// File: rtl/guess_judge.sv
// Judge stage: collects keypad digits, validates a submitted guess and scores it
// one digit per cycle against the loaded secret.
module guess_judge
    import guess_pkg::*;
#(
    parameter int DIGITS    = DEF_DIGITS,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic                clk_div,
    input  logic                rst,
    input  logic                ans_load,
    input  logic [4*DIGITS-1:0] ans_in,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic                inCorrect,
    output logic                ansCorrect,
    output logic [2:0]          a_count,
    output logic [2:0]          b_count,
    output logic [4*DIGITS-1:0] guess_bcd,
    output logic [2:0]          digit_cnt,
    output logic [3:0]          try_cnt,
    output logic                game_over,
    output logic                busy
);

    state_t              r_state;
    logic [4*DIGITS-1:0] r_secret;
    logic [4*DIGITS-1:0] r_guess;
    logic [2:0]          r_digit_cnt;
    logic [3:0]          r_try_cnt;
    logic [2:0]          r_a_count;
    logic [2:0]          r_b_count;
    logic                r_in_correct;
    logic                r_ans_correct;
    logic [2:0]          r_idx;
    logic [2:0]          r_acc_a;
    logic [2:0]          r_acc_b;

    logic       w_ans_ok;
    logic       w_guess_ok;
    logic [3:0] w_g_digit;
    logic       w_hit_a;
    logic       w_hit_b;
    logic [2:0] w_a_sum;
    logic [2:0] w_b_sum;
    logic [3:0] w_try_inc;
    logic       w_last;
    logic       w_key_digit;
    logic       w_guess_full;

    guess_digit_check #(.DIGITS(DIGITS)) u_ans_check (
        .i_bcd   (ans_in),
        .o_valid (w_ans_ok)
    );

    guess_digit_check #(.DIGITS(DIGITS)) u_guess_check (
        .i_bcd   (r_guess),
        .o_valid (w_guess_ok)
    );

    // Guess digit under the score index against every secret position.
    always_comb begin
        w_g_digit = '0;
        w_hit_a   = 1'b0;
        w_hit_b   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == 3'(i)) w_g_digit = r_guess[4*i +: 4];
        end
        for (int j = 0; j < DIGITS; j++) begin
            if (w_g_digit == r_secret[4*j +: 4]) begin
                if (r_idx == 3'(j)) w_hit_a = 1'b1;
                else                w_hit_b = 1'b1;
            end
        end
    end

    assign w_a_sum      = r_acc_a + 3'(w_hit_a);
    assign w_b_sum      = r_acc_b + 3'(w_hit_b);
    assign w_try_inc    = r_try_cnt + 4'd1;
    assign w_last       = (r_idx == 3'(DIGITS - 1));
    assign w_key_digit  = (key_code <= 4'd9);
    assign w_guess_full = (r_digit_cnt == 3'(DIGITS));

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_LOCKED;
            r_secret      <= '0;
            r_guess       <= '0;
            r_digit_cnt   <= '0;
            r_try_cnt     <= '0;
            r_a_count     <= '0;
            r_b_count     <= '0;
            r_in_correct  <= 1'b0;
            r_ans_correct <= 1'b0;
            r_idx         <= '0;
            r_acc_a       <= '0;
            r_acc_b       <= '0;
        end else if (ans_load && w_ans_ok) begin
            // New game wins over any key and aborts a scoring pass in flight.
            r_state       <= ST_ENTRY;
            r_secret      <= ans_in;
            r_guess       <= '0;
            r_digit_cnt   <= '0;
            r_try_cnt     <= '0;
            r_a_count     <= '0;
            r_b_count     <= '0;
            r_in_correct  <= 1'b0;
            r_ans_correct <= 1'b0;
            r_idx         <= '0;
            r_acc_a       <= '0;
            r_acc_b       <= '0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (key_valid) begin
                        if (w_key_digit) begin
                            if (!w_guess_full) begin
                                r_guess     <= {r_guess[4*DIGITS-5:0], key_code};
                                r_digit_cnt <= r_digit_cnt + 3'd1;
                            end
                        end else if (key_code == KEY_CLR) begin
                            r_guess     <= '0;
                            r_digit_cnt <= '0;
                        end else if (key_code == KEY_ENT) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_guess_full && w_guess_ok) begin
                        r_in_correct <= 1'b1;
                        r_idx        <= '0;
                        r_acc_a      <= '0;
                        r_acc_b      <= '0;
                        r_state      <= ST_SCORE;
                    end else begin
                        r_in_correct  <= 1'b0;
                        r_a_count     <= '0;
                        r_b_count     <= '0;
                        r_ans_correct <= 1'b0;
                        r_guess       <= '0;
                        r_digit_cnt   <= '0;
                        r_state       <= ST_ENTRY;
                    end
                end
                ST_SCORE: begin
                    if (w_last) begin
                        r_a_count     <= w_a_sum;
                        r_b_count     <= w_b_sum;
                        r_ans_correct <= (w_a_sum == 3'(DIGITS));
                        r_try_cnt     <= w_try_inc;
                        if (w_a_sum == 3'(DIGITS)) begin
                            r_state <= ST_WON;
                        end else if (w_try_inc == 4'(MAX_TRIES)) begin
                            r_state <= ST_LOST;
                        end else begin
                            r_state     <= ST_ENTRY;
                            r_guess     <= '0;
                            r_digit_cnt <= '0;
                        end
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_acc_a <= w_a_sum;
                        r_acc_b <= w_b_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inCorrect  = r_in_correct;
    assign ansCorrect = r_ans_correct;
    assign a_count    = r_a_count;
    assign b_count    = r_b_count;
    assign guess_bcd  = r_guess;
    assign digit_cnt  = r_digit_cnt;
    assign try_cnt    = r_try_cnt;
    assign game_over  = (r_state == ST_WON) || (r_state == ST_LOST);
    assign busy       = (r_state == ST_CHECK) || (r_state == ST_SCORE);

endmodule
